// File: rtl/psum_ofifo_pkg.sv
// Shared sizing for the MAC array output path: default array geometry
// and the FIFO pointer-width helper used by the column FIFOs.
package psum_ofifo_pkg;

    // Defaults shared with the MAC array and the downstream SFU.
    localparam int COL_DEF     = 8;
    localparam int PSUM_BW_DEF = 16;
    localparam int DEPTH_DEF   = 64;

    // Pointer width: index bits plus one wrap bit that separates full from empty.
    function automatic int ptr_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/ofifo_col.sv
// Single-column partial-sum FIFO. The head entry is presented combinationally
// on out. The parent gates rd so that a pop is only requested when legal.
module ofifo_col
    import psum_ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [psum_bw-1:0] in,
    output logic [psum_bw-1:0] out,
    output logic               full,
    output logic               empty
);

    localparam int PW = ptr_w(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic               wr_ok;
    logic               rd_ok;

    // Fullness is taken from the pointers at cycle start. A write into a
    // full column is therefore dropped even if a pop frees space this cycle.
    assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
    assign empty = (wptr == rptr);
    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;
    assign out   = mem[rptr[PW-2:0]];

    // Storage write. The contents are not reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[PW-2:0]] <= in;
        end
    end

    // Pointer update. The pointers wrap naturally through the extra MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + PW'(1);
            if (rd_ok) rptr <= rptr + PW'(1);
        end
    end

endmodule

// File: rtl/psum_ofifo.sv
// Output buffer for the MAC array. It absorbs the skewed per-column partial
// sums and releases only complete, column-aligned rows.
//
// Handshake: o_valid is high while every column holds data. A row pops on a
// rising edge where rd && o_valid, and the popped row appears on the
// registered out after that edge. rd while o_valid is low is ignored.
// Writes are per column and are accepted whenever that column is not full.
// A write that hits a full column is dropped and latches o_overflow.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth   = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic                   o_overflow,
    output logic [col*psum_bw-1:0] out
);

    logic [col-1:0]         full_v;
    logic [col-1:0]         empty_v;
    logic [col*psum_bw-1:0] head;
    logic                   rd_acc;

    // Status is derived only from the pointers. There is no combinational path from rd.
    assign o_full  = |full_v;
    assign o_ready = ~o_full;
    assign o_valid = ~|empty_v;
    assign rd_acc  = rd && o_valid;

    for (genvar c = 0; c < col; c++) begin : g_col
        ofifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[c]),
            .rd    (rd_acc),
            .in    (in[psum_bw*c +: psum_bw]),
            .out   (head[psum_bw*c +: psum_bw]),
            .full  (full_v[c]),
            .empty (empty_v[c])
        );
    end

    // Row output register. It loads all column heads on an accepted pop and holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (rd_acc) begin
            out <= head;
        end
    end

    // Sticky overflow flag. It is set by any write into a column that is full at cycle start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_overflow <= 1'b0;
        end else if (|(wr & full_v)) begin
            o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed bench for psum_ofifo with col=8, psum_bw=16, depth=4.
module tb_psum_ofifo;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 4;
    localparam int W   = COL * BW;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   in;
    logic [COL-1:0] wr;
    logic           rd;
    logic           o_full, o_ready, o_valid, o_overflow;
    logic [W-1:0]   out;

    int n_cmp = 0;
    int n_err = 0;

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .wr         (wr),
        .rd         (rd),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_overflow (o_overflow),
        .out        (out)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock, then sample 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr = '0;
        rd = 1'b0;
        in = '0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic push_row(input logic [BW-1:0] v);
        in = {COL{v}};
        wr = '1;
        step();
        wr = '0;
    endtask

    task automatic pop_row();
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, W'(o_valid), W'(0));
        chk({tag, "_full"}, W'(o_full), W'(0));
        chk({tag, "_ready"}, W'(o_ready), W'(1));
        chk({tag, "_ovf"}, W'(o_overflow), W'(0));
        chk({tag, "_out"}, out, '0);
    endtask

    initial begin
        logic [W-1:0] exp_row;

        // reset then idle
        reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
        #12;
        chk_reset_state("rst");
        reset = 1'b0;
        step();
        rd = 1'b1;
        repeat (3) step();
        rd = 1'b0;
        chk("idle_rd_out", out, '0);
        chk("idle_rd_valid", W'(o_valid), W'(0));

        // skewed wavefront write
        for (int c = 0; c < COL; c++) begin
            in[BW*c +: BW] = 16'h0100 + 16'(c);
            exp_row[BW*c +: BW] = 16'h0100 + 16'(c);
        end
        for (int c = 0; c < COL; c++) begin
            wr = COL'(1) << c;
            step();
            chk($sformatf("skew_valid_%0d", c), W'(o_valid), W'(c == COL - 1));
        end
        wr = '0;
        pop_row();
        chk("skew_out", out, exp_row);
        chk("skew_valid_after", W'(o_valid), W'(0));

        // fill to full, then overflow, then drain in order
        do_reset();
        for (int k = 1; k <= DEP; k++) push_row(16'(k));
        chk("fill_full", W'(o_full), W'(1));
        chk("fill_ready", W'(o_ready), W'(0));
        chk("fill_ovf_before", W'(o_overflow), W'(0));
        push_row(16'd5);
        chk("fill_ovf", W'(o_overflow), W'(1));
        for (int k = 1; k <= DEP; k++) begin
            pop_row();
            chk($sformatf("fill_rd_%0d", k), out, {COL{16'(k)}});
        end
        chk("fill_empty", W'(o_valid), W'(0));
        pop_row();
        chk("fill_rd_ignored", out, {COL{16'd4}});

        // wrap-around with interleaved write/read
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            push_row(16'(k));
            pop_row();
            chk($sformatf("wrap_rd_%0d", k), out, {COL{16'(k)}});
        end
        chk("wrap_ovf", W'(o_overflow), W'(0));
        chk("wrap_valid", W'(o_valid), W'(0));

        // full with simultaneous read and write
        do_reset();
        for (int k = 0; k < DEP; k++) push_row(16'h0011 + 16'(k));
        in = {COL{16'h0099}};
        wr = '1;
        rd = 1'b1;
        step();
        wr = '0;
        rd = 1'b0;
        chk("simul_out", out, {COL{16'h0011}});
        chk("simul_ovf", W'(o_overflow), W'(1));
        chk("simul_full", W'(o_full), W'(0));
        for (int k = 1; k < DEP; k++) begin
            pop_row();
            chk($sformatf("simul_rd_%0d", k), out, {COL{16'h0011 + 16'(k)}});
        end
        chk("simul_empty", W'(o_valid), W'(0));

        // async reset mid-stream with 3 entries held
        do_reset();
        for (int k = 1; k <= DEP; k++) push_row(16'h0020 + 16'(k));
        push_row(16'h00ee);
        pop_row();
        chk("ar_pre_out", out, {COL{16'h0021}});
        chk("ar_pre_valid", W'(o_valid), W'(1));
        chk("ar_pre_ovf", W'(o_overflow), W'(1));
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("ar");
        step();
        reset = 1'b0;
        step();
        step();
        chk("ar_post_valid", W'(o_valid), W'(0));
        push_row(16'h0077);
        chk("ar_new_valid", W'(o_valid), W'(1));
        pop_row();
        chk("ar_new_out", out, {COL{16'h0077}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
